spawn_scheduler: RTL

Sequences enemy respawns for the boxhead game: it watches the per-enemy alive flags, enforces a frame-counted cooldown between spawns, and picks the next dead enemy round-robin. It then hands that enemy a spawn position through a req/ack handshake. It sits between the per-enemy `gamelogic` instances and the enemy movement blocks. It replaces free-running per-enemy respawn timers with one shared, wave-aware scheduler.

---
 rtl/boxhead_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 37 +++
 rtl/spawn_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/boxhead_pkg.sv
// ---------------------------------------------------------------------------
// boxhead_pkg
// Shared types and constants for the boxhead enemy spawn logic:
//   spawn_state_t  - spawn scheduler FSM state encoding
//   spawn_pt_t     - one (X,Y) spawn position, 9 bits per coordinate
//   SPAWN_PTS      - the four fixed spawn positions, indexed by sp_idx
//   LFSR_SEED/TAPS - 8-bit Fibonacci LFSR used when SPAWN_LFSR_EN is defined
// ---------------------------------------------------------------------------
package boxhead_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COOLDOWN,
      ST_SELECT,
      ST_ISSUE
   } spawn_state_t;

   typedef struct packed {
      logic [8:0] x;
      logic [8:0] y;
   } spawn_pt_t;

   localparam int NUM_SPAWN_PTS = 4;

   // Screen corners inset by 16 pixels, in sp_idx order.
   localparam spawn_pt_t SPAWN_PTS [NUM_SPAWN_PTS] = '{
      '{x: 9'd16,  y: 9'd16},
      '{x: 9'd464, y: 9'd16},
      '{x: 9'd16,  y: 9'd224},
      '{x: 9'd464, y: 9'd224}
   };

   // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: grants the first set request bit at or
// above ptr, searching upward and wrapping back to bit 0.
//   req   in  N      request bits
//   ptr   in  PW     search start position (0..N-1)
//   grant out N      one-hot grant, zero when no request is set
//   valid out 1      at least one request was set
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          valid
);

   logic [PW-1:0] idx;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, otherwise the unassigned paths infer latches.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spawn_scheduler.sv
// ---------------------------------------------------------------------------
// spawn_scheduler
// Shared, wave-aware enemy respawn sequencer. Counts game frames of cooldown,
// picks the next dead enemy round-robin and hands it a spawn position over a
// Spawn_Req/Spawn_Ack handshake. Also tracks kills and the current wave; the
// cooldown shrinks by 4 frames per wave down to MIN_COOLDOWN.
//
// Ports:
//   Clk, Reset_n                 clock, asynchronous active-low reset
//   game_frame_clk_rising_edge   one-cycle pulse per game frame
//   Game_Start                   run enable; low forces IDLE
//   Enemy_Alive [ENEMY_NUM]      alive flag per enemy
//   Spawn_Ack   [ENEMY_NUM]      per-enemy spawn acknowledge
//   Spawn_Req   [ENEMY_NUM]      one-hot spawn request (registered)
//   Spawn_X, Spawn_Y [9]         spawn position, valid while Spawn_Req != 0
//   Wave [4]                     current wave, saturating at 15
//   Kill_Count [8]               total kills modulo 256
//
// Build option: define SPAWN_LFSR_EN to pick spawn points from an LFSR that
// steps every frame; otherwise spawn points rotate on each accepted spawn.
// ---------------------------------------------------------------------------
module spawn_scheduler
   import boxhead_pkg::*;
#(
   parameter int ENEMY_NUM    = 4,
   parameter int RESPAWN_TIME = 40,
   parameter int MIN_COOLDOWN = 8,
   parameter int WAVE_KILLS   = 10
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 game_frame_clk_rising_edge,
   input  logic                 Game_Start,
   input  logic [ENEMY_NUM-1:0] Enemy_Alive,
   input  logic [ENEMY_NUM-1:0] Spawn_Ack,
   output logic [ENEMY_NUM-1:0] Spawn_Req,
   output logic [8:0]           Spawn_X,
   output logic [8:0]           Spawn_Y,
   output logic [3:0]           Wave,
   output logic [7:0]           Kill_Count
);

   localparam int         PW    = $clog2(ENEMY_NUM);
   localparam logic [9:0] RT10  = 10'(RESPAWN_TIME);
   localparam logic [9:0] MIN10 = 10'(MIN_COOLDOWN);
   localparam logic [7:0] WK8   = 8'(WAVE_KILLS);

   spawn_state_t         state, next_state;
   logic [9:0]           cnt;
   logic [PW-1:0]        rr_ptr;
   logic [1:0]           sp_idx;
   logic [ENEMY_NUM-1:0] alive_q;
   logic [ENEMY_NUM-1:0] deaths;
   logic [ENEMY_NUM-1:0] grant;
   logic                 grant_valid;
   logic [PW-1:0]        grant_idx;
   logic [PW-1:0]        rr_next;
   logic [3:0]           death_cnt;
   logic [9:0]           wave_x4;
   logic [9:0]           cd_base;
   logic [9:0]           cooldown;
   logic [7:0]           wave_kills;
   logic [7:0]           kills_sum;
   logic                 any_dead;
   logic                 ack_hit;
   logic                 frame;

   assign frame    = game_frame_clk_rising_edge;
   assign any_dead = |(~Enemy_Alive);
   // Only the granted bit can match, since Spawn_Req is one-hot in ISSUE.
   assign ack_hit  = (state == ST_ISSUE) && (|(Spawn_Ack & Spawn_Req));
   assign deaths   = alive_q & ~Enemy_Alive;

   rr_arbiter #(.N(ENEMY_NUM)) u_rr_arbiter (
      .req   (~Enemy_Alive),
      .ptr   (rr_ptr),
      .grant (grant),
      .valid (grant_valid)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < ENEMY_NUM; i++) begin
         if (grant[i]) grant_idx = PW'(i);
      end
      rr_next = (grant_idx == PW'(ENEMY_NUM - 1)) ? '0 : grant_idx + PW'(1);
   end

   always_comb begin
      death_cnt = '0;
      for (int i = 0; i < ENEMY_NUM; i++) begin
         death_cnt = death_cnt + 4'(deaths[i]);
      end
      kills_sum = wave_kills + {4'b0000, death_cnt};
   end

   // max(RESPAWN_TIME - 4*Wave, MIN_COOLDOWN) without letting the
   // subtraction wrap once 4*Wave passes the base time.
   always_comb begin
      wave_x4  = {4'b0000, Wave, 2'b00};
      cd_base  = (RT10 > wave_x4) ? (RT10 - wave_x4) : '0;
      cooldown = (cd_base > MIN10) ? cd_base : MIN10;
   end

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of its neighbours, independent of block ordering.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (!Game_Start) begin
         next_state = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:     next_state = ST_COOLDOWN;
            ST_COOLDOWN: if (cnt == '0 && any_dead) next_state = ST_SELECT;
            // An enemy may have revived since COOLDOWN saw it dead.
            ST_SELECT:   next_state = grant_valid ? ST_ISSUE : ST_COOLDOWN;
            ST_ISSUE:    if (ack_hit) next_state = ST_COOLDOWN;
            default:     next_state = ST_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Cooldown counter, round-robin pointer and spawn request outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt       <= '0;
         rr_ptr    <= '0;
         Spawn_Req <= '0;
         Spawn_X   <= '0;
         Spawn_Y   <= '0;
      end else if (!Game_Start) begin
         cnt       <= cooldown;
         Spawn_Req <= '0;
      end else begin
         unique case (state)
            ST_IDLE: cnt <= cooldown;
            ST_COOLDOWN: begin
               if (frame && cnt != '0) cnt <= cnt - 10'd1;
            end
            ST_SELECT: begin
               if (grant_valid) begin
                  Spawn_Req <= grant;
                  Spawn_X   <= SPAWN_PTS[sp_idx].x;
                  Spawn_Y   <= SPAWN_PTS[sp_idx].y;
                  rr_ptr    <= rr_next;
               end
            end
            // A frame pulse in the ack cycle is ignored: reload takes priority.
            ST_ISSUE: begin
               if (ack_hit) begin
                  Spawn_Req <= '0;
                  cnt       <= cooldown;
               end
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Spawn-point index
   // -------------------------------------------------------------------------
`ifdef SPAWN_LFSR_EN
   logic [7:0] lfsr;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)   lfsr <= LFSR_SEED;
      else if (frame) lfsr <= lfsr_step(lfsr);
   end

   assign sp_idx = lfsr[1:0];
`else
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                  sp_idx <= '0;
      else if (Game_Start && ack_hit) sp_idx <= sp_idx + 2'd1;
   end
`endif

   // -------------------------------------------------------------------------
   // Kill and wave tracking (runs regardless of Game_Start)
   // -------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         alive_q    <= '0;
         Kill_Count <= '0;
         wave_kills <= '0;
         Wave       <= '0;
      end else begin
         alive_q    <= Enemy_Alive;
         Kill_Count <= Kill_Count + {4'b0000, death_cnt};
         if (kills_sum >= WK8) begin
            wave_kills <= kills_sum - WK8;
            if (Wave != 4'hF) Wave <= Wave + 4'd1;
         end else begin
            wave_kills <= kills_sum;
         end
      end
   end

endmodule
